// File: rtl/adder_slice_sequencer.sv
// Sequences a shared SLICE-bit external adder across WIDTH/SLICE cycles, LS slice first,
// with edge-detected LoadB/Run push-buttons and registered operands, sum and carry.
module adder_slice_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadB,
    input  logic             Run,
    input  logic [WIDTH-1:0] SW,
    output logic [SLICE-1:0] slice_a,
    output logic [SLICE-1:0] slice_b,
    output logic             slice_cin,
    input  logic [SLICE-1:0] slice_s,
    input  logic             slice_cout,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             co_q, co_d;
    logic             run_q, loadb_q;
    logic             run_press, loadb_press;

    // Buttons are active low; a press is the released-to-pressed transition.
    assign run_press   = run_q & ~Run;
    assign loadb_press = loadb_q & ~LoadB;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            run_q   <= 1'b1;
            loadb_q <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            run_q   <= Run;
            loadb_q <= LoadB;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        c_d       = c_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        co_d      = co_q;
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (loadb_press) begin
                    b_d = SW;
                end
                if (run_press) begin
                    a_d     = SW;
                    sum_d   = '0;
                    co_d    = 1'b0;
                    k_d     = '0;
                    c_d     = 1'b0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                slice_a   = a_q[SLICE*k_q +: SLICE];
                slice_b   = b_q[SLICE*k_q +: SLICE];
                slice_cin = (k_q == '0) ? 1'b0 : c_q;
                sum_d[SLICE*k_q +: SLICE] = slice_s;
                c_d = slice_cout;
                if (k_q == KW'(N - 1)) begin
                    co_d    = slice_cout;
                    state_d = StDone;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                // Leaving needs Run released, so a held button cannot restart an add.
                if (Run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign A    = a_q;
    assign B    = b_q;
    assign Sum  = sum_q;
    assign CO   = co_q;
    assign Busy = (state_q == StAdd);
    assign Done = (state_q == StDone);

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Randomized and directed checks of adder_slice_sequencer against plain-arithmetic expectations.
module tb_adder_slice_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;
    localparam int unsigned N     = WIDTH / SLICE;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             LoadB = 1'b1;
    logic             Run = 1'b1;
    logic [WIDTH-1:0] SW = '0;
    logic [SLICE-1:0] slice_a, slice_b, slice_s;
    logic             slice_cin, slice_cout;
    logic [WIDTH-1:0] A, B, Sum;
    logic             CO, Busy, Done;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    // The external adder slice the block time-shares.
    assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

    adder_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .LoadB     (LoadB),
        .Run       (Run),
        .SW        (SW),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_s   (slice_s),
        .slice_cout(slice_cout),
        .A         (A),
        .B         (B),
        .Sum       (Sum),
        .CO        (CO),
        .Busy      (Busy),
        .Done      (Done)
    );

    task automatic test_reset();
        Reset = 1'b0;
        Run   = 1'b1;
        LoadB = 1'b1;
        repeat (2) @(negedge Clk);
        total++;
        if ({A, B, Sum, CO, Busy, Done} !== '0) begin
            bad++;
            $display("FAIL reset_regs: A=%h B=%h Sum=%h CO=%b Busy=%b Done=%b, want all 0",
                     A, B, Sum, CO, Busy, Done);
        end
        total++;
        if ({slice_a, slice_b, slice_cin} !== '0) begin
            bad++;
            $display("FAIL reset_slice: a=%h b=%h cin=%b, want 0", slice_a, slice_b, slice_cin);
        end
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic load_b(input logic [WIDTH-1:0] v);
        SW    = v;
        LoadB = 1'b0;
        @(negedge Clk);
        LoadB = 1'b1;
        total++;
        if (B !== v) begin
            bad++;
            $display("FAIL load_b: B=%h want %h", B, v);
        end
        @(negedge Clk);
    endtask

    // Presses Run with SW=a (and LoadB too when both) and checks every step against
    // plain arithmetic on a + b. Injects a LoadB press of 0x1234 mid-add when asked.
    task automatic run_add(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b_in, input bit both,
                           input bit inject, input bit release_run);
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   full;
        logic [31:0]      m, part;
        b     = both ? a : b_in;
        full  = {1'b0, a} + {1'b0, b};
        SW    = a;
        Run   = 1'b0;
        if (both) LoadB = 1'b0;
        @(negedge Clk);
        LoadB = 1'b1;
        total++;
        if (Busy !== 1'b1 || Sum !== '0 || slice_a !== a[3:0] || slice_b !== b[3:0]
            || slice_cin !== 1'b0) begin
            bad++;
            $display("FAIL %s step0: Busy=%b Sum=%h a=%h b=%h cin=%b, want 1 0 %h %h 0",
                     tag, Busy, Sum, slice_a, slice_b, slice_cin, a[3:0], b[3:0]);
        end
        for (int k = 0; k < N; k++) begin
            if (inject && k == 0) begin
                SW    = 16'h1234;
                LoadB = 1'b0;
            end
            @(negedge Clk);
            LoadB = 1'b1;
            m = (32'd1 << (SLICE * (k + 1))) - 32'd1;
            total++;
            if (Sum !== (full[WIDTH-1:0] & m[WIDTH-1:0])) begin
                bad++;
                $display("FAIL %s partial%0d: Sum=%h want %h", tag, k, Sum,
                         full[WIDTH-1:0] & m[WIDTH-1:0]);
            end
            if (k < N - 1) begin
                part = ({16'b0, a} & m) + ({16'b0, b} & m);
                total++;
                if (Busy !== 1'b1 || Done !== 1'b0 || slice_a !== a[SLICE*(k+1) +: SLICE]
                    || slice_b !== b[SLICE*(k+1) +: SLICE]
                    || slice_cin !== part[SLICE*(k+1)]) begin
                    bad++;
                    $display("FAIL %s step%0d: Busy=%b Done=%b a=%h b=%h cin=%b, want 1 0 %h %h %b",
                             tag, k + 1, Busy, Done, slice_a, slice_b, slice_cin,
                             a[SLICE*(k+1) +: SLICE], b[SLICE*(k+1) +: SLICE],
                             part[SLICE*(k+1)]);
                end
            end
        end
        total++;
        if (Done !== 1'b1 || Busy !== 1'b0 || CO !== full[WIDTH] || Sum !== full[WIDTH-1:0]
            || A !== a || B !== b || {slice_a, slice_b, slice_cin} !== '0) begin
            bad++;
            $display("FAIL %s result: Done=%b Busy=%b CO=%b Sum=%h A=%h B=%h, want 1 0 %b %h %h %h",
                     tag, Done, Busy, CO, Sum, A, B, full[WIDTH], full[WIDTH-1:0], a, b);
        end
        if (release_run) begin
            Run = 1'b1;
            @(negedge Clk);
            total++;
            if (Done !== 1'b0 || Busy !== 1'b0 || Sum !== full[WIDTH-1:0]) begin
                bad++;
                $display("FAIL %s release: Done=%b Busy=%b Sum=%h, want 0 0 %h",
                         tag, Done, Busy, Sum, full[WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_basic();
        load_b(16'h0001);
        run_add("basic", 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_carry();
        load_b(16'hFFFF);
        run_add("carry", 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_ripple();
        load_b(16'h00F1);
        run_add("ripple", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            load_b(b);
            run_add("random", a, b, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_run_held();
        int busy_cnt = 0;
        load_b(16'h0345);
        run_add("held", 16'h0F00, 16'h0345, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
        end
        total++;
        if (busy_cnt !== 0 || Done !== 1'b1 || Sum !== 16'h1245) begin
            bad++;
            $display("FAIL held: extra_busy=%0d Done=%b Sum=%h, want 0 1 1245", busy_cnt, Done, Sum);
        end
        Run = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_loadb_during_add();
        load_b(16'h0777);
        run_add("loadb_in_add", 16'h1111, 16'h0777, 1'b0, 1'b1, 1'b1);
        run_add("rerun", 16'h1111, 16'h0777, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        run_add("simul", 16'h8001, 16'h8001, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        load_b(16'hABCD);
        SW  = 16'h1234;
        Run = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        Run   = 1'b1;
        @(negedge Clk);
        total++;
        if ({A, B, Sum, CO, Busy, Done, slice_a, slice_b, slice_cin} !== '0) begin
            bad++;
            $display("FAIL reset_mid: A=%h B=%h Sum=%h CO=%b Busy=%b Done=%b, want all 0",
                     A, B, Sum, CO, Busy, Done);
        end
        Reset = 1'b1;
        @(negedge Clk);
        load_b(16'h0001);
        run_add("after_reset", 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ripple();
        test_random();
        test_run_held();
        test_loadb_during_add();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
